// File: rtl/echo_detector_if.sv
// Beamformed sample stream into the echo detector and the latched echo report out of it.
interface echo_detector_if #(
   parameter int DATA_WIDTH = 16,
   parameter int TIME_WIDTH = 24
);
   logic                  start_in;
   logic [TIME_WIDTH-1:0] time_in;
   logic [DATA_WIDTH-1:0] sample_in;
   logic                  sample_valid_in;
   logic                  busy_out;
   logic                  echo_out;
   logic                  echo_valid_out;
   logic [TIME_WIDTH-1:0] echo_time_out;
   logic [DATA_WIDTH-1:0] echo_amp_out;

   modport master (
      output start_in, time_in, sample_in, sample_valid_in,
      input  busy_out, echo_out, echo_valid_out, echo_time_out, echo_amp_out
   );

   modport slave (
      input  start_in, time_in, sample_in, sample_valid_in,
      output busy_out, echo_out, echo_valid_out, echo_time_out, echo_amp_out
   );
endinterface

// File: rtl/echo_detector.sv
// First-echo detector: learns a DC baseline while blanked, then flags the first run of CONFIRM_COUNT
// samples with |x - baseline| >= THRESH_HI; report one cycle after the confirming sample. No backpressure. ECHO_PEAK_TRACK_EN adds peak tracking.
module echo_detector #(
   parameter int DATA_WIDTH     = 16,
   parameter int TIME_WIDTH     = 24,
   parameter int BLANK_CYCLES   = 524288,
   parameter int THRESH_HI      = 200,
   parameter int THRESH_LO      = 150,
   parameter int CONFIRM_COUNT  = 4,
   parameter int BASELINE_SHIFT = 4
) (
   input logic            clk_in,
   input logic            rst_n_in,
   echo_detector_if.slave bus
);
   typedef enum logic [1:0] {IDLE, BLANK, LISTEN, DETECTED} state_t;

   localparam int ACC_W = DATA_WIDTH + BASELINE_SHIFT;
   localparam int CNT_W = $clog2(CONFIRM_COUNT + 1);
   localparam logic [31:0]           BLANK_LAST   = 32'(BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0]      CONFIRM_LAST = CNT_W'(CONFIRM_COUNT - 1);
   localparam logic [DATA_WIDTH-1:0] HI           = DATA_WIDTH'(THRESH_HI);

   if (THRESH_LO > THRESH_HI || CONFIRM_COUNT < 1) begin : g_param_check
      $error("echo_detector: THRESH_LO must not exceed THRESH_HI and CONFIRM_COUNT must be >= 1");
   end

   state_t                state_q, state_d;
   logic [31:0]           blank_cnt_q;
   logic [ACC_W-1:0]      acc_q;
   logic                  seeded_q;
   logic [CNT_W-1:0]      cnt_q;
   logic [TIME_WIDTH-1:0] cand_time_q;
   logic [DATA_WIDTH-1:0] cand_amp_q;
   logic                  echo_q;
   logic                  echo_vld_q;
   logic [TIME_WIDTH-1:0] echo_time_q;
   logic [DATA_WIDTH-1:0] echo_amp_q;
`ifdef ECHO_PEAK_TRACK_EN
   localparam logic [DATA_WIDTH-1:0] LO = DATA_WIDTH'(THRESH_LO);
   logic                  peak_frozen_q;
`endif

   logic [DATA_WIDTH-1:0] baseline;
   logic [DATA_WIDTH-1:0] mag;
   logic                  hit;
   logic                  confirm;
   logic [DATA_WIDTH-1:0] run_amp;
   logic [TIME_WIDTH-1:0] run_time;
   logic [ACC_W-1:0]      acc_next;

   // acc never exceeds (2^DATA_WIDTH-1) << BASELINE_SHIFT, so the IIR update cannot overflow ACC_W
   always_comb begin
      baseline = acc_q[ACC_W-1:BASELINE_SHIFT];
      mag      = (bus.sample_in >= baseline) ? (bus.sample_in - baseline)
                                              : (baseline - bus.sample_in);
      hit      = bus.sample_valid_in && (mag >= HI);
      confirm  = (state_q == LISTEN) && hit && (cnt_q == CONFIRM_LAST);
      run_amp  = (cnt_q == '0 || mag > cand_amp_q) ? mag : cand_amp_q;
      run_time = (cnt_q == '0) ? bus.time_in : cand_time_q;
      acc_next = seeded_q ? (acc_q + ACC_W'(bus.sample_in) - (acc_q >> BASELINE_SHIFT))
                          : (ACC_W'(bus.sample_in) << BASELINE_SHIFT);
   end

   always_comb begin
      state_d = state_q;
      if (bus.start_in) begin
         state_d = (BLANK_CYCLES == 0) ? LISTEN : BLANK;
      end else begin
         case (state_q)
            BLANK:    if (blank_cnt_q == BLANK_LAST) state_d = LISTEN;
            LISTEN:   if (confirm) state_d = DETECTED;
            default:  state_d = state_q;
         endcase
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         blank_cnt_q   <= '0;
         acc_q         <= '0;
         seeded_q      <= 1'b0;
         cnt_q         <= '0;
         cand_time_q   <= '0;
         cand_amp_q    <= '0;
         echo_q        <= 1'b0;
         echo_vld_q    <= 1'b0;
         echo_time_q   <= '0;
         echo_amp_q    <= '0;
`ifdef ECHO_PEAK_TRACK_EN
         peak_frozen_q <= 1'b0;
`endif
      end else begin
         echo_vld_q <= 1'b0;
         if (bus.start_in) begin
            blank_cnt_q   <= '0;
            acc_q         <= '0;
            seeded_q      <= 1'b0;
            cnt_q         <= '0;
            cand_time_q   <= '0;
            cand_amp_q    <= '0;
            echo_q        <= 1'b0;
            echo_time_q   <= '0;
            echo_amp_q    <= '0;
`ifdef ECHO_PEAK_TRACK_EN
            peak_frozen_q <= 1'b0;
`endif
         end else begin
            case (state_q)
               BLANK: begin
                  blank_cnt_q <= blank_cnt_q + 32'd1;
                  if (bus.sample_valid_in) begin
                     acc_q    <= acc_next;
                     seeded_q <= 1'b1;
                  end
               end
               LISTEN: begin
                  if (hit) begin
                     cnt_q       <= cnt_q + CNT_W'(1);
                     cand_time_q <= run_time;
                     cand_amp_q  <= run_amp;
                     if (confirm) begin
                        echo_q      <= 1'b1;
                        echo_vld_q  <= 1'b1;
                        echo_time_q <= run_time;
                        echo_amp_q  <= run_amp;
                     end
                  end else if (bus.sample_valid_in) begin
                     cnt_q <= '0;
                  end
               end
`ifdef ECHO_PEAK_TRACK_EN
               // Follow the echo peak until the first sample that drops below the release level
               DETECTED: begin
                  if (bus.sample_valid_in && !peak_frozen_q) begin
                     if (mag >= LO) begin
                        if (mag > echo_amp_q) echo_amp_q <= mag;
                     end else begin
                        peak_frozen_q <= 1'b1;
                     end
                  end
               end
`endif
               default: ;
            endcase
         end
      end
   end

   assign bus.busy_out       = (state_q == BLANK) || (state_q == LISTEN);
   assign bus.echo_out       = echo_q;
   assign bus.echo_valid_out = echo_vld_q;
   assign bus.echo_time_out  = echo_time_q;
   assign bus.echo_amp_out   = echo_amp_q;
endmodule

// File: tb/tb_echo_detector.sv
// Scoreboarded bench for echo_detector: directed scenarios plus randomized bursts against a burst-level model.
module tb_echo_detector;
   localparam int DW    = 16;
   localparam int TW    = 24;
   localparam int BLANK = 64;
   localparam int HI    = 200;
   localparam int LO    = 150;
   localparam int CC    = 4;
   localparam int SH    = 4;

   typedef struct {bit busy; bit echo; bit vld; int tim; int amp;} status_t;
   typedef struct {int tim; int amp;} event_t;
   typedef struct {int tim; int mag;} hit_t;

   logic clk_100mhz = 1'b0;
   logic rst_n      = 1'b0;
   always #5 clk_100mhz = ~clk_100mhz;

   echo_detector_if #(.DATA_WIDTH(DW), .TIME_WIDTH(TW)) bus ();

   echo_detector #(
      .DATA_WIDTH(DW), .TIME_WIDTH(TW), .BLANK_CYCLES(BLANK), .THRESH_HI(HI),
      .THRESH_LO(LO), .CONFIRM_COUNT(CC), .BASELINE_SHIFT(SH)
   ) dut (
      .clk_in(clk_100mhz),
      .rst_n_in(rst_n),
      .bus(bus)
   );

   int n_vec = 0;
   int n_err = 0;
   status_t exp_q[$];
   event_t  evt_q[$];

   // Reference model state: burst phase, blank time elapsed, baseline accumulator and the current qualifying run
   int   m_phase;   // 0 idle, 1 blanking, 2 listening, 3 echo found
   int   m_elapsed;
   int   m_acc;
   bit   m_seeded;
   hit_t m_run[$];
   bit   m_echo;
   int   m_time, m_amp;
   bit   m_frozen;
   int   tnow;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_status(input bit vld);
      status_t s;
      s.busy = (m_phase == 1 || m_phase == 2);
      s.echo = m_echo;
      s.vld  = vld;
      s.tim  = m_time;
      s.amp  = m_amp;
      exp_q.push_back(s);
   endtask

   task automatic model_clear();
      m_elapsed = 0; m_acc = 0; m_seeded = 0; m_run.delete();
      m_echo = 0; m_time = 0; m_amp = 0; m_frozen = 0;
   endtask

   task automatic model_step(input bit st, input bit v, input int t, input int s);
      bit pulse = 0;
      int bl, mag, best;
      bl  = m_acc / (1 << SH);
      mag = (s > bl) ? s - bl : bl - s;
      if (st) begin
         model_clear();
         m_phase = (BLANK == 0) ? 2 : 1;
      end else if (m_phase == 1) begin
         if (v) begin
            m_acc    = m_seeded ? m_acc + s - m_acc / (1 << SH) : s * (1 << SH);
            m_seeded = 1;
         end
         m_elapsed++;
         if (m_elapsed == BLANK) m_phase = 2;
      end else if (m_phase == 2) begin
         if (v && mag >= HI) m_run.push_back('{t, mag});
         else if (v) m_run.delete();
         if (m_run.size() == CC) begin
            best = 0;
            foreach (m_run[i]) if (m_run[i].mag > best) best = m_run[i].mag;
            m_echo = 1; m_time = m_run[0].tim; m_amp = best; pulse = 1; m_phase = 3;
            evt_q.push_back('{m_time, m_amp});
         end
      end else if (m_phase == 3) begin
`ifdef ECHO_PEAK_TRACK_EN
         if (v && !m_frozen) begin
            if (mag >= LO) m_amp = (mag > m_amp) ? mag : m_amp;
            else m_frozen = 1;
         end
`endif
      end
      push_status(pulse);
   endtask

   task automatic cyc(input bit st, input bit v, input int s);
      @(posedge clk_100mhz);
      #2;
      rst_n               = 1'b1;
      bus.start_in        = st;
      bus.sample_valid_in = v;
      bus.sample_in       = DW'(s);
      bus.time_in         = TW'(tnow);
      model_step(st, v, tnow, s);
      tnow++;
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_100mhz);
         #2;
         rst_n = 1'b0;
         bus.start_in = 1'b0;
         bus.sample_valid_in = 1'b0;
         m_phase = 0;
         model_clear();
         push_status(1'b0);
      end
   endtask

   task automatic blank_fill(input int s);
      for (int i = 0; i < BLANK; i++) cyc(1'b0, 1'b1, s);
   endtask

   // Monitor: compares the DUT against the queued expectations one cycle at a time
   initial begin
      status_t e;
      event_t  ev;
      forever begin
         @(posedge clk_100mhz);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("busy_out", int'(bus.busy_out), int'(e.busy));
            chk("echo_out", int'(bus.echo_out), int'(e.echo));
            chk("echo_valid_out", int'(bus.echo_valid_out), int'(e.vld));
            chk("echo_time_out", int'(bus.echo_time_out), e.tim);
            chk("echo_amp_out", int'(bus.echo_amp_out), e.amp);
         end
         if (bus.echo_valid_out) begin
            if (evt_q.size() == 0) begin
               chk("unexpected echo pulse", 1, 0);
            end else begin
               ev = evt_q.pop_front();
               chk("pulse time", int'(bus.echo_time_out), ev.tim);
               chk("pulse amp", int'(bus.echo_amp_out), ev.amp);
            end
         end
      end
   end

   initial begin
      int base, s, len;
      bus.start_in = 1'b0; bus.sample_valid_in = 1'b0; bus.sample_in = '0; bus.time_in = '0;
      tnow = 0;
      m_phase = 0;
      model_clear();
      do_reset(3);

      // Idle without start: samples ignored
      for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 800);

      // Reset in the middle of a blanking window, then samples without start
      cyc(1'b1, 1'b0, 0);
      for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 500);
      do_reset(2);
      for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 900);

      // Basic detect on a 500 baseline, followed by peak-tracking samples
      cyc(1'b1, 1'b0, 0);
      blank_fill(500);
      tnow = 990;
      for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 500);
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 800);
      cyc(1'b0, 1'b0, 0);
      cyc(1'b0, 1'b1, 900);
      cyc(1'b0, 1'b1, 850);
      cyc(1'b0, 1'b1, 500);
      cyc(1'b0, 1'b1, 1400);
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 800);

      // Glitch rejection: first run broken after three samples
      cyc(1'b1, 1'b0, 0);
      blank_fill(500);
      tnow = 1995;
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 500);
      cyc(1'b0, 1'b1, 800); cyc(1'b0, 1'b1, 800); cyc(1'b0, 1'b1, 800);
      cyc(1'b0, 1'b1, 500);
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 800);
      cyc(1'b0, 1'b0, 0);

      // Negative swing with a spike inside the blanking window
      cyc(1'b1, 1'b0, 0);
      for (int i = 0; i < BLANK; i++) cyc(1'b0, 1'b1, (i == 2) ? 2000 : 900);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 900);
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 600);
      cyc(1'b0, 1'b0, 0);

      // Re-arm with start coincident with a qualifying sample; BLANK with no valid samples keeps baseline 0
      cyc(1'b1, 1'b1, 800);
      for (int i = 0; i < BLANK; i++) cyc(1'b0, 1'b0, 0);
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 250);

      // Randomized bursts
      for (int b = 0; b < 25; b++) begin
         cyc(1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, 4000));
         tnow = 0;
         base = $urandom_range(0, 3000);
         len  = BLANK + $urandom_range(10, 150);
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 7) == 0) s = base + ($urandom_range(0, 1) ? 1 : -1) * int'($urandom_range(100, 600));
            else s = base + int'($urandom_range(0, 60)) - 30;
            if (s < 0) s = 0;
            if (s > 65535) s = 65535;
            if ($urandom_range(0, 299) == 0) do_reset(1);
            else cyc($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, s);
         end
      end

      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 0);
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk_100mhz);
      @(posedge clk_100mhz);
      #3;
      chk("status queue drained", exp_q.size(), 0);
      chk("event queue drained", evt_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
